pc_unit_ras: RTL and testbench

- Parametrised successor to the current program counter.
- Word-addressed PC with stall, PC-relative branch and jump, register jump (JR), call (CLL) and a hardware return-address stack (RAS) for RET.
- Sits in the IF stage. Control pulses come from the ID/EX redirect logic; pc_out drives the instruction memory address.

---
 rtl/pc_unit_ras.sv | 165 ++++++++++++++++
 tb/tb_pc_unit_ras.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras.sv
// Program counter for the IF stage, with relative branch/jump, JR, CLL and a circular return-address stack.
// Optional sticky RAS error flags and the ctrl_err pulse are enabled by defining PC_RAS_ERR_FLAGS_EN.
module pc_unit_ras #(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = DATA_W,
    parameter int                OFF_W     = 14,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pc_write,
    input  logic                           branch,
    input  logic                           jump,
    input  logic                           call,
    input  logic                           ret,
    input  logic                           jr,
    input  logic [OFF_W-1:0]               offset,
    input  logic [OFF_W-1:0]               target,
    input  logic [ADDR_W-1:0]              jump_addr,
    output logic [ADDR_W-1:0]              pc_out,
    output logic [ADDR_W-1:0]              return_addr,
    output logic [ADDR_W-1:0]              ras_top,
    output logic [$clog2(RAS_DEPTH):0]     ras_count,
    output logic                           ras_empty,
    output logic                           ras_full,
    output logic                           ras_underflow,
    output logic                           ras_overflow,
    output logic                           ctrl_err
);

    localparam int                PTR_W    = $clog2(RAS_DEPTH);
    localparam int                CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(RAS_DEPTH);

    function automatic logic signed [ADDR_W-1:0] sext_off(input logic [OFF_W-1:0] v);
        logic signed [OFF_W-1:0] s;
        s = signed'(v);
        return ADDR_W'(s);
    endfunction

    logic [ADDR_W-1:0] r_pc;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [ADDR_W-1:0] r_ras [RAS_DEPTH];

    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_br_tgt;
    logic [ADDR_W-1:0] w_jmp_tgt;
    logic [ADDR_W-1:0] w_ras_rd;
    logic [ADDR_W-1:0] w_pc_next;
    logic [PTR_W-1:0]  w_top_idx;
    logic              w_ras_empty;
    logic              w_ras_full;
    logic              w_take_jr;
    logic              w_take_ret;
    logic              w_take_call;
    logic              w_take_jump;
    logic              w_take_branch;
    logic              w_push;
    logic              w_pop;

    assign w_pc_inc    = r_pc + ADDR_W'(1);
    assign w_br_tgt    = r_pc + ADDR_W'(sext_off(offset));
    assign w_jmp_tgt   = r_pc + ADDR_W'(sext_off(target));
    assign w_ras_empty = (r_count == '0);
    assign w_ras_full  = (r_count == CNT_FULL);
    // Top of stack is the slot just below the write pointer; wraps naturally.
    assign w_top_idx   = r_wr_ptr - PTR_W'(1);
    assign w_ras_rd    = r_ras[w_top_idx];

    // Redirect priority: jr > ret > call > jump > branch > increment.
    always_comb begin
        w_take_jr     = pc_write & jr;
        w_take_ret    = pc_write & ~jr & ret;
        w_take_call   = pc_write & ~jr & ~ret & call;
        w_take_jump   = pc_write & ~jr & ~ret & ~call & jump;
        w_take_branch = pc_write & ~jr & ~ret & ~call & ~jump & branch;
    end

    assign w_push = w_take_call;
    assign w_pop  = w_take_ret & ~w_ras_empty;

    always_comb begin
        w_pc_next = w_pc_inc;
        if (w_take_jr) begin
            w_pc_next = jump_addr;
        end else if (w_take_ret) begin
            w_pc_next = w_ras_empty ? w_pc_inc : w_ras_rd;
        end else if (w_take_call || w_take_jump) begin
            w_pc_next = w_jmp_tgt;
        end else if (w_take_branch) begin
            w_pc_next = w_br_tgt;
        end
    end

    // ---- PC and RAS control state ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (pc_write) begin
            r_pc <= w_pc_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (!w_ras_full) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else if (w_pop) begin
                r_wr_ptr <= r_wr_ptr - PTR_W'(1);
                r_count  <= r_count - CNT_W'(1);
            end
        end
    end

    // ---- RAS storage: data only, contents meaningless while count is 0 ----
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ras[r_wr_ptr] <= w_pc_inc;
        end
    end

    assign pc_out      = r_pc;
    assign return_addr = w_pc_inc;
    assign ras_top     = w_ras_empty ? '0 : w_ras_rd;
    assign ras_count   = r_count;
    assign ras_empty   = w_ras_empty;
    assign ras_full    = w_ras_full;

`ifdef PC_RAS_ERR_FLAGS_EN
    logic       r_ras_overflow;
    logic       r_ras_underflow;
    logic       r_ctrl_err;
    logic [2:0] w_ctrl_cnt;

    assign w_ctrl_cnt = 3'(jr) + 3'(ret) + 3'(call) + 3'(jump) + 3'(branch);

    // ---- Error flags: sticky RAS faults, one-cycle control conflict ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ras_overflow  <= 1'b0;
            r_ras_underflow <= 1'b0;
            r_ctrl_err      <= 1'b0;
        end else begin
            r_ctrl_err <= pc_write && (w_ctrl_cnt > 3'd1);
            if (w_take_call && w_ras_full) begin
                r_ras_overflow <= 1'b1;
            end
            if (w_take_ret && w_ras_empty) begin
                r_ras_underflow <= 1'b1;
            end
        end
    end

    assign ras_overflow  = r_ras_overflow;
    assign ras_underflow = r_ras_underflow;
    assign ctrl_err      = r_ctrl_err;
`else
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
    assign ctrl_err      = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit_ras.sv
// Bench for pc_unit_ras: directed scenarios plus randomized traffic against a queue-based stack model.
module tb_pc_unit_ras;

    localparam int ADDR_W = 32;
    localparam int OFF_W  = 14;
    localparam int DEPTH  = 8;
`ifdef PC_RAS_ERR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset, pc_write, branch, jump, call, ret, jr;
    logic [OFF_W-1:0]  offset, target;
    logic [ADDR_W-1:0] jump_addr;
    logic [ADDR_W-1:0] pc_out, return_addr, ras_top;
    logic [3:0]        ras_count;
    logic              ras_empty, ras_full, ras_underflow, ras_overflow, ctrl_err;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit [31:0] m_pc;
    bit [31:0] m_stk[$];
    bit        m_uf, m_of, m_err;

    pc_unit_ras #(.ADDR_W(ADDR_W), .OFF_W(OFF_W), .RAS_DEPTH(DEPTH), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .pc_write(pc_write), .branch(branch), .jump(jump),
        .call(call), .ret(ret), .jr(jr), .offset(offset), .target(target),
        .jump_addr(jump_addr), .pc_out(pc_out), .return_addr(return_addr),
        .ras_top(ras_top), .ras_count(ras_count), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_underflow(ras_underflow), .ras_overflow(ras_overflow),
        .ctrl_err(ctrl_err)
    );

    always #5 clk = ~clk;

    function automatic int sx(input logic [OFF_W-1:0] v);
        int o;
        o = int'(v);
        if (o >= (1 << (OFF_W - 1))) o = o - (1 << OFF_W);
        return o;
    endfunction

    task automatic model_step();
        int n;
        if (reset) begin
            m_pc = 0; m_stk.delete(); m_uf = 0; m_of = 0; m_err = 0;
        end else if (!pc_write) begin
            m_err = 0;
        end else begin
            n = int'(jr) + int'(ret) + int'(call) + int'(jump) + int'(branch);
            m_err = (n > 1);
            if (jr) m_pc = jump_addr;
            else if (ret) begin
                if (m_stk.size() > 0) m_pc = m_stk.pop_back();
                else begin m_pc = m_pc + 1; m_uf = 1; end
            end else if (call) begin
                m_stk.push_back(m_pc + 1);
                if (m_stk.size() > DEPTH) begin void'(m_stk.pop_front()); m_of = 1; end
                m_pc = m_pc + sx(target);
            end else if (jump) m_pc = m_pc + sx(target);
            else if (branch) m_pc = m_pc + sx(offset);
            else m_pc = m_pc + 1;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        reset = 0; branch = 0; jump = 0; call = 0; ret = 0; jr = 0;
        offset = '0; target = '0; jump_addr = '0;
    endtask

    task automatic test_reset();
        clr(); reset = 1; pc_write = 0;
        tick();
        reset = 0;
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h expected 0", pc_out); end
        checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", ras_count); end
        checks++; if (ras_empty !== 1'b1 || ras_full !== 1'b0) begin errors++; $display("FAIL reset_empty_full: got %b%b expected 10", ras_empty, ras_full); end
        checks++; if (ras_top !== 32'h0) begin errors++; $display("FAIL reset_top: got %0h expected 0", ras_top); end
        checks++; if ({ras_underflow, ras_overflow, ctrl_err} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {ras_underflow, ras_overflow, ctrl_err}); end
    endtask

    task automatic test_increment_stall();
        clr(); pc_write = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++; if (pc_out !== 32'(i)) begin errors++; $display("FAIL incr_pc: got %0h expected %0h", pc_out, i); end
        end
        checks++; if (return_addr !== 32'h4) begin errors++; $display("FAIL return_addr: got %0h expected 4", return_addr); end
        pc_write = 0;
        call = 1; jump = 1; target = 14'h0005;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (pc_out !== 32'h3) begin errors++; $display("FAIL stall_pc: got %0h expected 3", pc_out); end
            checks++; if (ras_count !== 4'd0 || ctrl_err !== 1'b0) begin errors++; $display("FAIL stall_state: got count %0d err %b expected 0 0", ras_count, ctrl_err); end
        end
        clr();
    endtask

    task automatic test_branch_jump();
        clr(); pc_write = 1;
        branch = 1; offset = 14'h3FFE;
        tick();
        checks++; if (pc_out !== 32'h1) begin errors++; $display("FAIL branch_back: got %0h expected 1", pc_out); end
        branch = 0; jump = 1; target = 14'h0005;
        tick();
        checks++; if (pc_out !== 32'h6) begin errors++; $display("FAIL jump_fwd: got %0h expected 6", pc_out); end
        clr();
    endtask

    task automatic test_call_ret();
        clr(); pc_write = 1;
        jr = 1; jump_addr = 32'h10;
        tick();
        jr = 0; call = 1; target = 14'h0020;
        tick();
        checks++; if (pc_out !== 32'h30) begin errors++; $display("FAIL call_pc: got %0h expected 30", pc_out); end
        checks++; if (ras_top !== 32'h11) begin errors++; $display("FAIL call_top: got %0h expected 11", ras_top); end
        checks++; if (ras_count !== 4'd1) begin errors++; $display("FAIL call_count: got %0d expected 1", ras_count); end
        call = 0; ret = 1;
        tick();
        checks++; if (pc_out !== 32'h11) begin errors++; $display("FAIL ret_pc: got %0h expected 11", pc_out); end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ret_empty: got %b expected 1", ras_empty); end
        clr();
    endtask

    task automatic test_overflow();
        clr(); pc_write = 1;
        jr = 1; jump_addr = 32'h0;
        tick();
        jr = 0; call = 1; target = 14'h0001;
        repeat (9) tick();
        checks++; if (ras_count !== 4'd8 || ras_full !== 1'b1) begin errors++; $display("FAIL ovf_count: got %0d full %b expected 8 1", ras_count, ras_full); end
        checks++; if (ras_overflow !== FLAGS) begin errors++; $display("FAIL ovf_flag: got %b expected %b", ras_overflow, FLAGS); end
        checks++; if (pc_out !== 32'h9) begin errors++; $display("FAIL ovf_pc: got %0h expected 9", pc_out); end
        call = 0; ret = 1;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++; if (pc_out !== 32'(9 - i)) begin errors++; $display("FAIL ovf_ret_order: got %0h expected %0h", pc_out, 9 - i); end
        end
        checks++; if (ras_empty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b expected 1", ras_empty); end
        clr();
    endtask

    task automatic test_underflow();
        clr(); pc_write = 1;
        jr = 1; jump_addr = 32'h40;
        tick();
        jr = 0; ret = 1;
        tick();
        checks++; if (pc_out !== 32'h41) begin errors++; $display("FAIL uf_pc: got %0h expected 41", pc_out); end
        checks++; if (ras_underflow !== FLAGS || ras_count !== 4'd0) begin errors++; $display("FAIL uf_flag: got %b cnt %0d expected %b 0", ras_underflow, ras_count, FLAGS); end
        ret = 0;
        repeat (5) tick();
        checks++; if (ras_underflow !== FLAGS) begin errors++; $display("FAIL uf_sticky: got %b expected %b", ras_underflow, FLAGS); end
        reset = 1;
        tick();
        reset = 0;
        checks++; if (ras_underflow !== 1'b0 || ras_overflow !== 1'b0) begin errors++; $display("FAIL uf_reset: got %b%b expected 00", ras_underflow, ras_overflow); end
        clr();
    endtask

    task automatic test_priority();
        clr(); pc_write = 1;
        jr = 1; call = 1; jump_addr = 32'h100;
        tick();
        checks++; if (pc_out !== 32'h100) begin errors++; $display("FAIL prio_pc: got %0h expected 100", pc_out); end
        checks++; if (ras_count !== 4'd0) begin errors++; $display("FAIL prio_nopush: got %0d expected 0", ras_count); end
        checks++; if (ctrl_err !== FLAGS) begin errors++; $display("FAIL prio_err: got %b expected %b", ctrl_err, FLAGS); end
        clr();
        tick();
        checks++; if (ctrl_err !== 1'b0) begin errors++; $display("FAIL prio_err_pulse: got %b expected 0", ctrl_err); end
        // A return beats a call; the call must not push.
        call = 1; ret = 1; target = 14'h0010;
        tick();
        checks++; if (pc_out !== 32'h102 || ras_count !== 4'd0) begin errors++; $display("FAIL prio_ret_call: got %0h cnt %0d expected 102 0", pc_out, ras_count); end
        clr();
    endtask

    task automatic test_wrap();
        clr(); pc_write = 1;
        jr = 1; jump_addr = 32'hFFFF_FFFF;
        tick();
        checks++; if (return_addr !== 32'h0) begin errors++; $display("FAIL wrap_link: got %0h expected 0", return_addr); end
        jr = 0;
        tick();
        checks++; if (pc_out !== 32'h0) begin errors++; $display("FAIL wrap_pc: got %0h expected 0", pc_out); end
        branch = 1; offset = 14'h2000;
        tick();
        checks++; if (pc_out !== 32'hFFFF_E000) begin errors++; $display("FAIL wrap_branch: got %0h expected ffffe000", pc_out); end
        clr();
    endtask

    task automatic test_random();
        bit [31:0] etop;
        for (int n = 0; n < 600; n++) begin
            reset     = ($urandom_range(0, 99) == 0);
            pc_write  = ($urandom_range(0, 9) != 0);
            jr        = ($urandom_range(0, 11) == 0);
            ret       = ($urandom_range(0, 3) == 0);
            call      = ($urandom_range(0, 2) == 0);
            jump      = ($urandom_range(0, 7) == 0);
            branch    = ($urandom_range(0, 5) == 0);
            offset    = OFF_W'($urandom);
            target    = OFF_W'($urandom);
            jump_addr = $urandom;
            tick();
            etop = (m_stk.size() > 0) ? m_stk[$] : 32'h0;
            checks++; if (pc_out !== m_pc) begin errors++; $display("FAIL rnd_pc[%0d]: got %0h expected %0h", n, pc_out, m_pc); end
            checks++; if (return_addr !== m_pc + 1) begin errors++; $display("FAIL rnd_link[%0d]: got %0h expected %0h", n, return_addr, m_pc + 1); end
            checks++; if (ras_top !== etop) begin errors++; $display("FAIL rnd_top[%0d]: got %0h expected %0h", n, ras_top, etop); end
            checks++; if (ras_count !== 4'(m_stk.size())) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", n, ras_count, m_stk.size()); end
            checks++; if (ras_empty !== (m_stk.size() == 0) || ras_full !== (m_stk.size() == DEPTH)) begin errors++; $display("FAIL rnd_empty_full[%0d]: got %b%b size %0d", n, ras_empty, ras_full, m_stk.size()); end
            checks++; if ({ras_underflow, ras_overflow, ctrl_err} !== ({m_uf, m_of, m_err} & {3{FLAGS}})) begin errors++; $display("FAIL rnd_flags[%0d]: got %b expected %b", n, {ras_underflow, ras_overflow, ctrl_err}, {m_uf, m_of, m_err} & {3{FLAGS}}); end
        end
        clr();
    endtask

    initial begin
        clr(); pc_write = 0;
        test_reset();
        test_increment_stall();
        test_branch_jump();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_priority();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
